disp_value_ctrl: RTL and testbench

- Upstream stage of the hexdriver bank on the CPU board.
- Accepts a binary value from the CPU's display register and converts it to per-digit 4-bit codes, one for each hexdriver instance.
- Supports hex mode or decimal mode, with optional leading-zero blanking.
- Decimal conversion is an iterative double-dabble, one bit per clock. Displayed digits update atomically, so the display never shows a partial result.

---
 rtl/disp_pkg.sv | 24 ++
 rtl/disp_value_ctrl_if.sv | 39 +++
 rtl/bcd_dabble_step.sv | 30 +++
 rtl/disp_value_ctrl.sv | 122 ++++++++++++
 tb/tb_disp_value_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the display value controller.
// Conversion FSM states, BCD adjust constants and the blank segment code.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ        = 4'd3;
  localparam logic [6:0] BLANK_SEG      = 7'b1111111;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_value_ctrl_if.sv
// Value-in / digits-out bundle between the CPU display register
// and the hexdriver bank.
interface disp_value_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_value;
  logic                  in_dec;
  logic                  blank_lz;
  logic [4*DIGITS-1:0]   digits;
  logic [DIGITS-1:0]     digit_blank;
  logic                  out_valid;

  modport master (
    output in_valid,
    output in_value,
    output in_dec,
    output blank_lz,
    input  in_ready,
    input  digits,
    input  digit_blank,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  in_value,
    input  in_dec,
    input  blank_lz,
    output in_ready,
    output digits,
    output digit_blank,
    output out_valid
  );

endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add-3 on digits >= 5, then shift
// the incoming binary MSB into the bottom of the BCD register.
module bcd_dabble_step
  import disp_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic [4*DIGITS-1:0] bcd,
  input  logic                msb,
  output logic [4*DIGITS-1:0] nxt
);

  localparam int BW = 4 * DIGITS;

  logic [BW-1:0] adj;

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= BCD_ADJ_THRESH) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + BCD_ADJ;
      end else begin
        adj[4*i +: 4] = bcd[4*i +: 4];
      end
    end
  end

  assign nxt = (adj << 1) | BW'(msb);

endmodule

// File: rtl/disp_value_ctrl.sv
// Binary to per-digit code converter, hex or iterative decimal,
// with leading-zero blanking and atomic digit commit.
module disp_value_ctrl
  import disp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input logic               clk,
  input logic               rst_n,
  disp_value_ctrl_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  if ((pow10(DIGITS) <= (64'd1 << WIDTH)) ||
      (4 * DIGITS < WIDTH)) begin : g_bad_param
    $error("disp_value_ctrl: DIGITS too small for WIDTH");
  end

  state_t              state;
  state_t              nxt;
  logic [WIDTH-1:0]    bin;
  logic [BW-1:0]       bcd;
  logic [BW-1:0]       step;
  logic [CW-1:0]       cnt;
  logic                blz;
  logic                acc;
  logic [DIGITS-1:0]   blank_nxt;
  logic [BW-1:0]       digits_q;
  logic [DIGITS-1:0]   blank_q;
  logic                ov_q;

  assign bus.in_ready    = (state == IDLE);
  assign bus.digits      = digits_q;
  assign bus.digit_blank = blank_q;
  assign bus.out_valid   = ov_q;
  assign acc = bus.in_valid && (state == IDLE);

  bcd_dabble_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .bcd (bcd),
    .msb (bin[WIDTH-1]),
    .nxt (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (acc) nxt = bus.in_dec ? CONV : COMMIT;
      CONV:   if (cnt == '0) nxt = COMMIT;
      COMMIT: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      blz <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            blz <= bus.blank_lz;
            if (bus.in_dec) begin
              bin <= bus.in_value;
              bcd <= '0;
              cnt <= CW'(WIDTH - 1);
            end else begin
              bcd <= BW'(bus.in_value);
            end
          end
        end
        CONV: begin
          bcd <= step;
          bin <= {bin[WIDTH-2:0], 1'b0};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A digit blanks only when it and everything above it is zero.
  always_comb begin
    logic z;
    blank_nxt = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z && (bcd[4*i +: 4] == 4'd0);
      blank_nxt[i] = blz && z;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      blank_q  <= '0;
      ov_q     <= 1'b0;
    end else begin
      ov_q <= (state == COMMIT);
      if (state == COMMIT) begin
        digits_q <= bcd;
        blank_q  <= blank_nxt;
      end
    end
  end

endmodule

// File: tb/tb_disp_value_ctrl.sv
// Directed plus random checks of disp_value_ctrl against
// an arithmetic digit model.
module tb_disp_value_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  disp_value_ctrl_if #(.WIDTH(16), .DIGITS(5)) bus ();

  disp_value_ctrl #(
    .WIDTH  (16),
    .DIGITS (5)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Digits by division, blanking by magnitude against base**i.
  function automatic void model(input int v,
                                input bit dec,
                                input bit blz,
                                output logic [19:0] d,
                                output logic [4:0] b);
    longint p;
    int base;
    base = dec ? 10 : 16;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      d[4*i +: 4] = 4'((v / p) % base);
      b[i] = blz && (i > 0) && (v < p);
      p = p * base;
    end
  endfunction

  task automatic xfer(input int v, input bit dec,
                      input bit blz, input string tag);
    logic [19:0] ed;
    logic [4:0]  eb;
    logic [19:0] pd;
    logic [4:0]  pb;
    bit          flick;
    bit          seen;
    int          n;
    model(v, dec, blz, ed, eb);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_value = 16'(v);
    bus.in_dec   = dec;
    bus.blank_lz = blz;
    pd = bus.digits;
    pb = bus.digit_blank;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_value = 16'($urandom);
    bus.in_dec   = 1'($urandom);
    bus.blank_lz = 1'($urandom);
    n = 0;
    flick = 1'b0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
      end else if (bus.digits !== pd ||
                   bus.digit_blank !== pb ||
                   bus.in_ready !== 1'b0) begin
        flick = 1'b1;
      end
    end
    chk({tag, "_lat"}, 32'(n), dec ? 32'd17 : 32'd1);
    chk({tag, "_dig"}, 32'(bus.digits), 32'(ed));
    chk({tag, "_blank"}, 32'(bus.digit_blank), 32'(eb));
    chk({tag, "_hold"}, 32'(flick), 32'd0);
    chk({tag, "_rdy_ov"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [19:0] ed;
    logic [4:0]  eb;
    logic [19:0] d1;
    logic [19:0] d2;
    int p1;
    int p2;
    int nov;
    bit badr;

    bus.in_valid = 1'b0;
    bus.in_value = '0;
    bus.in_dec   = 1'b0;
    bus.blank_lz = 1'b0;

    #12;
    chk("rst_dig", 32'(bus.digits), 32'd0);
    chk("rst_blank", 32'(bus.digit_blank), 32'd0);
    chk("rst_ov", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(bus.in_ready), 32'd1);
    chk("rel_ov", 32'(bus.out_valid), 32'd0);

    xfer(16'hBEEF, 1'b0, 1'b1, "hex_beef");
    xfer(65535, 1'b1, 1'b0, "dec_max");
    xfer(42, 1'b1, 1'b1, "dec_42");
    xfer(0, 1'b1, 1'b1, "dec_0");
    xfer(0, 1'b0, 1'b1, "hex_0");
    xfer(16'h00A0, 1'b0, 1'b0, "hex_a0");

    // Back-to-back: in_valid held high across two requests.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_value = 16'd123;
    bus.in_dec   = 1'b1;
    bus.blank_lz = 1'b0;
    @(posedge clk);
    #1;
    bus.in_value = 16'd9;
    p1 = -1;
    p2 = -1;
    d1 = '0;
    d2 = '0;
    badr = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (p1 >= 0 && c == p1 + 1) bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.out_valid) begin
        if (p1 < 0) begin
          p1 = c;
          d1 = bus.digits;
        end else if (p2 < 0) begin
          p2 = c;
          d2 = bus.digits;
        end
      end else if (p1 < 0 && bus.in_ready) begin
        badr = 1'b1;
      end
    end
    model(123, 1'b1, 1'b0, ed, eb);
    chk("b2b_p1", 32'(p1), 32'd17);
    chk("b2b_gap", 32'(p2 - p1), 32'd18);
    chk("b2b_d1", 32'(d1), 32'(ed));
    model(9, 1'b1, 1'b0, ed, eb);
    chk("b2b_d2", 32'(d2), 32'(ed));
    chk("b2b_busy", 32'(badr), 32'd0);

    // Abort a decimal conversion mid-flight.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_value = 16'd999;
    bus.in_dec   = 1'b1;
    bus.blank_lz = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_dig", 32'(bus.digits), 32'd0);
    chk("abort_blank", 32'(bus.digit_blank), 32'd0);
    chk("abort_ov", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(bus.in_ready), 32'd1);
    nov = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) nov++;
    end
    chk("abort_no_ov", 32'(nov), 32'd0);
    xfer(999, 1'b1, 1'b0, "dec_999");

    for (int k = 0; k < 20; k++) begin
      xfer(int'($urandom_range(0, 65535)),
           1'($urandom), 1'($urandom), "rnd");
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
